updown_mod_counter: RTL and testbench

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

---
 rtl/updown_mod_counter.sv | 103 ++++++++++
 tb/tb_updown_mod_counter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap or saturate mode and a registered wrap pulse.
// Optional parallel load is compiled in when UPDOWN_LOAD_EN is defined; otherwise
// the load/load_value ports exist but have no effect.
module updown_mod_counter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MODULUS = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             M,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] theOutput,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    // Top count value, held one bit wider so MODULUS = 2^WIDTH cannot overflow.
    localparam int unsigned     MAX_INT = MODULUS - 1;
    localparam logic [WIDTH:0]  MAX_EXT = MAX_INT[WIDTH:0];

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_inc_ext;
    logic [WIDTH:0]   w_dec_ext;
    logic             w_is_max;
    logic             w_is_min;
    logic [WIDTH-1:0] w_next;
    logic             w_next_wrap;

`ifdef UPDOWN_LOAD_EN
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_load_ext     = {1'b0, load_value};
    assign w_load_clamped = (w_load_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0]
                                                   : load_value;
`else
    logic w_unused_load;

    assign w_unused_load = load ^ (^load_value);
`endif

    assign w_count_ext = {1'b0, r_count};
    assign w_inc_ext   = w_count_ext + 1'b1;
    assign w_dec_ext   = w_count_ext - 1'b1;
    assign w_is_max    = (w_count_ext == MAX_EXT);
    assign w_is_min    = (r_count == '0);

    // Next count and wrap flag for an enabled step in the sampled direction and mode.
    always_comb begin
        w_next      = r_count;
        w_next_wrap = 1'b0;
        if (M) begin
            if (w_is_max) begin
                if (!sat) begin
                    w_next      = '0;
                    w_next_wrap = 1'b1;
                end
            end else begin
                w_next = w_inc_ext[WIDTH-1:0];
            end
        end else begin
            if (w_is_min) begin
                if (!sat) begin
                    w_next      = MAX_EXT[WIDTH-1:0];
                    w_next_wrap = 1'b1;
                end
            end else begin
                w_next = w_dec_ext[WIDTH-1:0];
            end
        end
    end

    // Count register: reset, then load, then enabled step; wrap is a one-cycle pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
`ifdef UPDOWN_LOAD_EN
        end else if (load) begin
            r_count <= w_load_clamped;
            r_wrap  <= 1'b0;
`endif
        end else if (en) begin
            r_count <= w_next;
            r_wrap  <= w_next_wrap;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign theOutput = r_count;
    assign wrap      = r_wrap;
    assign at_max    = w_is_max;
    assign at_min    = w_is_min;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a MODULUS=8 and a MODULUS=6 instance
// share one stimulus stream; expectations follow UPDOWN_LOAD_EN when defined.
module tb_updown_mod_counter;

    logic       clock;
    logic       reset_n;
    logic       en;
    logic       M;
    logic       sat;
    logic       load;
    logic [2:0] load_value;

    logic [2:0] o8, o6;
    logic       w8, w6, mx8, mx6, mn8, mn6;

    int n_tests;
    int n_fail;

    updown_mod_counter #(.WIDTH(3), .MODULUS(8)) u_d8 (
        .clock(clock), .reset_n(reset_n), .en(en), .M(M), .sat(sat),
        .load(load), .load_value(load_value),
        .theOutput(o8), .wrap(w8), .at_max(mx8), .at_min(mn8)
    );

    updown_mod_counter #(.WIDTH(3), .MODULUS(6)) u_d6 (
        .clock(clock), .reset_n(reset_n), .en(en), .M(M), .sat(sat),
        .load(load), .load_value(load_value),
        .theOutput(o6), .wrap(w6), .at_max(mx6), .at_min(mn6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag,
                            input logic [2:0] e8, input logic ew8,
                            input logic [2:0] e6, input logic ew6);
        chk({tag, " d8 count"}, {13'b0, o8}, {13'b0, e8});
        chk({tag, " d8 wrap"},  {15'b0, w8}, {15'b0, ew8});
        chk({tag, " d6 count"}, {13'b0, o6}, {13'b0, e6});
        chk({tag, " d6 wrap"},  {15'b0, w6}, {15'b0, ew6});
    endtask

    logic [2:0] up8 [9];
    logic [2:0] up6 [9];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        up8 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        up6 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};

        // Reset held for two edges with en=1
        reset_n = 1'b0; en = 1'b1; M = 1'b1; sat = 1'b0;
        load = 1'b0; load_value = 3'd0;
        tick();
        tick();
        chk_both("reset", 3'd0, 1'b0, 3'd0, 1'b0);
        chk("reset d8 at_min", {15'b0, mn8}, 16'd1);
        chk("reset d8 at_max", {15'b0, mx8}, 16'd0);
        chk("reset d6 at_min", {15'b0, mn6}, 16'd1);

        // Up count with wrap
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_both($sformatf("up%0d", i), up8[i], (up8[i] == 3'd0),
                     up6[i], (up6[i] == 3'd0));
        end

        // Mid-count reset, no partial update
        reset_n = 1'b0;
        tick();
        chk_both("midreset", 3'd0, 1'b0, 3'd0, 1'b0);

        // Down count with wrap
        reset_n = 1'b1; M = 1'b0;
        tick();
        chk_both("down0", 3'd7, 1'b1, 3'd5, 1'b1);
        chk("down0 d6 at_max", {15'b0, mx6}, 16'd1);
        tick();
        chk_both("down1", 3'd6, 1'b0, 3'd4, 1'b0);

        // Saturate up from 6 (d8) / 4 (d6)
        sat = 1'b1; M = 1'b1;
        tick();
        chk_both("sat0", 3'd7, 1'b0, 3'd5, 1'b0);
        tick();
        chk_both("sat1", 3'd7, 1'b0, 3'd5, 1'b0);
        tick();
        chk_both("sat2", 3'd7, 1'b0, 3'd5, 1'b0);
        tick();
        chk_both("sat3", 3'd7, 1'b0, 3'd5, 1'b0);
        chk("sat d8 at_max", {15'b0, mx8}, 16'd1);
        chk("sat d6 at_max", {15'b0, mx6}, 16'd1);
        M = 1'b0;
        tick();
        chk_both("satdown", 3'd6, 1'b0, 3'd4, 1'b0);

        // Hold with en=0
        en = 1'b0;
        tick();
        chk_both("hold", 3'd6, 1'b0, 3'd4, 1'b0);

        // Load with clamp, en and M ignored when load is compiled in
        load = 1'b1; load_value = 3'd7; en = 1'b1; M = 1'b0; sat = 1'b0;
        tick();
`ifdef UPDOWN_LOAD_EN
        chk_both("load7", 3'd7, 1'b0, 3'd5, 1'b0);
`else
        chk_both("load7", 3'd5, 1'b0, 3'd3, 1'b0);
`endif

        // Load together with reset: reset wins
        reset_n = 1'b0;
        tick();
        chk_both("loadreset", 3'd0, 1'b0, 3'd0, 1'b0);

        // Load strobe with en=0 over three edges
        reset_n = 1'b1; load = 1'b1; load_value = 3'd3; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef UPDOWN_LOAD_EN
            chk_both($sformatf("load3_%0d", i), 3'd3, 1'b0, 3'd3, 1'b0);
`else
            chk_both($sformatf("noload_%0d", i), 3'd0, 1'b0, 3'd0, 1'b0);
`endif
        end

        // Saturating down hold at 0 (no-load build) or step from 3 (load build)
        load = 1'b0; en = 1'b1; M = 1'b0; sat = 1'b1;
        tick();
`ifdef UPDOWN_LOAD_EN
        chk_both("satmin", 3'd2, 1'b0, 3'd2, 1'b0);
`else
        chk_both("satmin", 3'd0, 1'b0, 3'd0, 1'b0);
        chk("satmin d6 at_min", {15'b0, mn6}, 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
